// File: rtl/bcd_pkg.sv
// bcd_pkg
//   Shared constants, FSM state type and helpers for the serial BCD adder.
//   - BCD_W / BCD_MAX / BCD_CORR : digit width, largest legal digit, decimal
//     correction constant
//   - state_t                    : sequencer states (IDLE, ADD, DONE)
//   - cnt_width()                : digit-counter width, ceil(log2(n)), min 1
//   - add4()                     : the 4-bit binary adder, {carry, sum}
package bcd_pkg;

  localparam int BCD_W    = 4;
  localparam int BCD_MAX  = 9;
  localparam int BCD_CORR = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Smallest w with 2**w >= digits; never below 1 so DIGITS=1 still gets a
  // legal counter register.
  function automatic int cnt_width(input int digits);
    int w;
    w = 1;
    while ((1 << w) < digits) begin
      w = w + 1;
    end
    return w;
  endfunction

  // 4-bit binary adder with carry-in; result is {carry_out, sum[3:0]}.
  function automatic logic [4:0] add4(input logic [3:0] x,
                                      input logic [3:0] y,
                                      input logic       ci);
    return {1'b0, x} + {1'b0, y} + {4'b0000, ci};
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// bcd_digit_add
//   Combinational single-digit BCD adder: binary add of the two digits and
//   carry, a >9 detect on the 5-bit binary result, then a +6 correction add.
//   Ports:
//     a, b  in  4  operand digits (values above 9 are accepted unchecked)
//     cin   in  1  decimal carry in
//     sum   out 4  corrected decimal digit
//     cout  out 1  decimal carry out
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] a,
  input  logic [BCD_W-1:0] b,
  input  logic             cin,
  output logic [BCD_W-1:0] sum,
  output logic             cout
);

  logic [BCD_W:0] bin_t;
  logic [BCD_W:0] corr_t;
  logic           gt9;

  assign bin_t  = add4(a, b, cin);
  assign corr_t = add4(bin_t[BCD_W-1:0], 4'(BCD_CORR), 1'b0);

  // t > 9 when the binary add overflowed (16..19) or the low nibble is 10..15.
  assign gt9 = bin_t[BCD_W] | (bin_t[BCD_W-1:0] > 4'(BCD_MAX));

  assign sum = gt9 ? corr_t[BCD_W-1:0] : bin_t[BCD_W-1:0];

  // A low nibble of 10..15 is exactly the case where +6 carries out of bit 3,
  // so the decimal carry is the OR of both adder carries (equivalent to gt9).
  assign cout = bin_t[BCD_W] | corr_t[BCD_W];

endmodule

// File: rtl/bcd_serial_accumulator.sv
// bcd_serial_accumulator
//   Multi-digit BCD adder sequencer. Latches two packed DIGITS-digit BCD
//   operands and adds one digit pair per cycle, least-significant first,
//   through a single time-shared bcd_digit_add stage. The decimal carry
//   ripples through a register; the packed result is offered with a
//   valid/ready handshake.
//   Parameter: DIGITS (1..16) digits per operand.
//   Ports:
//     clk, rst             clock, asynchronous active-high reset
//     in_valid / in_ready  operand handshake (ready only in IDLE)
//     a, b                 packed BCD operands, digit i at [4i+3:4i]
//     cin                  decimal carry into digit 0
//     sum, cout            registered packed result and top-digit carry
//     out_valid/out_ready  result handshake (valid only in DONE)
//     err                  sticky non-BCD operand digit flag; port and logic
//                          exist only when BCD_DIGIT_CHECK_EN is defined
module bcd_serial_accumulator
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  cin,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  out_valid,
`ifdef BCD_DIGIT_CHECK_EN
  output logic                  err,
`endif
  input  logic                  out_ready
);

  localparam int W  = BCD_W * DIGITS;
  localparam int CW = cnt_width(DIGITS);

  state_t          state_reg;
  state_t          state_next;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;
  logic            carry_reg;
  logic [CW-1:0]   cnt_reg;
  logic [W-1:0]    sum_reg;
  logic [W-1:0]    sum_next;
  logic            cout_reg;
  logic            accept;
  logic            last_digit;
  logic [DIGITS-1:0] dig_we;
  logic [BCD_W-1:0]  dig_sum;
  logic              dig_cout;

  // Operand registers shift right one digit per ADD cycle, so the active
  // digit pair is always in the bottom nibble.
  bcd_digit_add u_digit (
    .a    (a_reg[BCD_W-1:0]),
    .b    (b_reg[BCD_W-1:0]),
    .cin  (carry_reg),
    .sum  (dig_sum),
    .cout (dig_cout)
  );

  assign last_digit = (cnt_reg == CW'(DIGITS - 1));

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept     = 1'b1;
          state_next = ADD;
        end
      end
      ADD: begin
        if (last_digit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        // in_valid is not looked at here: an accept can only happen once
        // the FSM is back in IDLE, the cycle after the output handshake.
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ------------------------------------------------------ digit write-back
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign dig_we[gi] = (state_reg == ADD) && (cnt_reg == CW'(gi));
      assign sum_next[gi*BCD_W +: BCD_W] =
        dig_we[gi] ? dig_sum : sum_reg[gi*BCD_W +: BCD_W];
    end
  endgenerate

  // ------------------------------------------------------------ datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
    end else begin
      sum_reg <= sum_next;
      if (accept) begin
        a_reg     <= a;
        b_reg     <= b;
        carry_reg <= cin;
        cnt_reg   <= '0;
      end else if (state_reg == ADD) begin
        a_reg     <= a_reg >> BCD_W;
        b_reg     <= b_reg >> BCD_W;
        carry_reg <= dig_cout;
        cnt_reg   <= cnt_reg + CW'(1);
        if (last_digit) begin
          cout_reg <= dig_cout;
        end
      end
    end
  end

  assign sum  = sum_reg;
  assign cout = cout_reg;

`ifdef BCD_DIGIT_CHECK_EN
  // chk_reg accumulates during ADD; err_reg is loaded with the final value on
  // the edge into DONE so err never shows a partial verdict.
  logic chk_reg;
  logic err_reg;
  logic dig_bad;

  assign dig_bad = (a_reg[BCD_W-1:0] > 4'(BCD_MAX)) ||
                   (b_reg[BCD_W-1:0] > 4'(BCD_MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_reg <= 1'b0;
      err_reg <= 1'b0;
    end else if (accept) begin
      chk_reg <= 1'b0;
      err_reg <= 1'b0;
    end else if (state_reg == ADD) begin
      chk_reg <= chk_reg | dig_bad;
      if (last_digit) begin
        err_reg <= chk_reg | dig_bad;
      end
    end
  end

  assign err = err_reg;
`endif

endmodule

// File: doc/bcd_serial_accumulator.md
# bcd_serial_accumulator

Multi-digit BCD adder sequencer. It latches two packed N-digit BCD operands and feeds one digit pair per cycle, least-significant first, through a single-digit BCD add stage built on the 4-bit binary adder. It ripples the decimal carry through a register and presents the packed result with a valid/ready handshake. It sits directly upstream of the 4-bit adder datapath and replaces N parallel digit adders with one time-shared digit stage.

## Interface
Parameters:
- DIGITS, 4, number of BCD digits per operand; legal range 1–16

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand request
- in_ready  out  1  block can accept operands
- a  in  4*DIGITS  packed BCD operand A; digit i is a[4i+3:4i]
- b  in  4*DIGITS  packed BCD operand B
- cin  in  1  decimal carry-in to digit 0
- sum  out  4*DIGITS  packed BCD result, registered
- cout  out  1  decimal carry-out of the top digit, registered
- out_valid  out  1  result available
- out_ready  in  1  consumer takes the result
- err  out  1  a non-BCD operand digit was seen; present only with BCD_DIGIT_CHECK_EN

## Operation
- FSM states: IDLE, ADD, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: latch a, b and cin into operand registers, clear the digit counter, go to ADD.
- ADD: one digit per cycle.
  - Binary stage: t = a_i + b_i + carry, 5 bits.
  - If t > 9: digit = (t + 6) mod 16, carry = 1.
  - Otherwise: digit = t[3:0], carry = 0.
  - Write the digit into sum[4i+3:4i].
  - After digit DIGITS-1: write cout, go to DONE.
- DONE:
  - out_valid=1.
  - On out_ready: go to IDLE.
  - sum, cout and err hold until the next accept.
- in_ready=0 in ADD and DONE. in_valid is ignored outside IDLE.
- Operand inputs may change freely after the accept edge.
- Digits > 9 are not rejected. The correction rule above is still applied deterministically.
- Reset values: state IDLE, in_ready=1, out_valid=0, sum=0, cout=0, err=0, digit counter 0, carry register 0.

## Timing
- Accept at edge k.
- Digit i is written at edge k+1+i.
- out_valid rises after edge k+DIGITS.
- Latency from accept to out_valid is DIGITS cycles. Minimum period between accepts is DIGITS+2 cycles with out_ready held high.
- in_valid and out_ready may both be high in DONE. Only the output handshake completes, and the new accept occurs no earlier than the following cycle in IDLE.
- With out_ready held low, out_valid stays high indefinitely and in_ready stays low. There is no result overwrite.
- rst asserted at any point, including mid-ADD, aborts the operation. All state returns to reset values immediately, and the partial sum is discarded.
- DIGITS=1: ADD lasts exactly one cycle.

## Configuration
- Macro BCD_DIGIT_CHECK_EN.
- Defined:
  - err port exists.
  - During ADD, a sticky flag is set if a_i > 9 or b_i > 9.
  - The flag is cleared on accept and on reset, and is visible on err from the DONE cycle onward.
  - The arithmetic result is unaffected.
- Undefined: no err port and no check logic. Behaviour is otherwise identical.

## Structure
- Package bcd_pkg:
  - BCD_W = 4
  - BCD_MAX = 9
  - BCD_CORR = 6
  - state enum (IDLE, ADD, DONE)
  - digit-counter width function, ceil(log2(DIGITS)), minimum 1
- One sub-module, bcd_digit_add: combinational; a 4-bit binary add, a >9 detect, then a +6 correction add. Both adds use the team's 4-bit adder.
- The top level holds the FSM, the operand/carry/counter registers and the result register.

## Test plan
- DIGITS=4, a=0x1234, b=0x4321, cin=0 -> sum=0x5555, cout=0, out_valid 4 cycles after accept.
- a=0x9999, b=0x0001, cin=0 -> sum=0x0000, cout=1; a=0x9999, b=0x9999, cin=1 -> sum=0x9999, cout=1.
- Hold out_ready=0 for 10 cycles after done -> out_valid and sum stable, in_ready=0, new in_valid ignored; then out_ready=1 -> IDLE next cycle, back-to-back accept works.
- Assert rst at the second ADD cycle of 0x5678+0x4321 -> immediately sum=0, out_valid=0, in_ready=1; a fresh 0x0005+0x0005 then gives sum=0x0010.
- BCD_DIGIT_CHECK_EN defined: a=0x00A1, b=0x0001 -> err=1 in DONE; next clean operation -> err=0.
- DIGITS=1: a=0x7, b=0x8, cin=1 -> sum=0x6, cout=1, latency 1 cycle.
